// File: rtl/regfile_sb_pkg.sv
// Shared LC-3b datapath types used by the register file, its interface and the operand muxes.
package lc3b_types;
    localparam int WORD_W = 16;
    localparam int NREGS  = 8;

    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [2:0]        lc3b_reg;
endpackage

// File: rtl/regfile_sb_if.sv
// Decode/write-back side bundle of the scoreboarded register file.
interface regfile_sb_if;
    import lc3b_types::*;

    logic       wb_load;
    lc3b_reg    wb_dest;
    lc3b_word   wb_data;
    lc3b_reg    src1;
    lc3b_reg    src2;
    logic       use1;
    logic       use2;
    logic       issue_valid;
    logic       issue_load;
    lc3b_reg    issue_dest;
    logic       flush;
    lc3b_word   rd_data1;
    lc3b_word   rd_data2;
    logic       stall;
    logic [7:0] busy;

    modport master (
        output wb_load, wb_dest, wb_data, src1, src2, use1, use2,
               issue_valid, issue_load, issue_dest, flush,
        input  rd_data1, rd_data2, stall, busy
    );

    modport slave (
        input  wb_load, wb_dest, wb_data, src1, src2, use1, use2,
               issue_valid, issue_load, issue_dest, flush,
        output rd_data1, rd_data2, stall, busy
    );
endinterface

// File: rtl/regfile_sb_mux8.sv
// Generic 8:1 word multiplexer used for the operand read ports.
module mux8 #(
    parameter int width = 16
) (
    input  logic [2:0]       sel,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic [width-1:0] c,
    input  logic [width-1:0] d,
    input  logic [width-1:0] e,
    input  logic [width-1:0] f,
    input  logic [width-1:0] g,
    input  logic [width-1:0] h,
    output logic [width-1:0] out
);
    always_comb begin
        out = a;
        case (sel)
            3'd0: out = a;
            3'd1: out = b;
            3'd2: out = c;
            3'd3: out = d;
            3'd4: out = e;
            3'd5: out = f;
            3'd6: out = g;
            3'd7: out = h;
            default: out = a;
        endcase
    end
endmodule

// File: rtl/regfile_sb.sv
// 8 x 16-bit register file with write-through read bypass and a per-register busy
// scoreboard that stalls issue on RAW and WAW hazards.
module regfile_sb
    import lc3b_types::*;
#(
    parameter int width = WORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  rf
);
    logic [width-1:0] r_regs [NREGS];
    logic [7:0]       r_busy;

    logic [7:0]       w_busy_nxt;
    logic [width-1:0] w_mux1;
    logic [width-1:0] w_mux2;
    logic             w_hit1;
    logic             w_hit2;
    logic             w_hitd;
    logic             w_haz1;
    logic             w_haz2;
    logic             w_waw;
    logic             w_stall;
    logic             w_accept;

    // A write-back in the current cycle both bypasses the read and releases the hazard.
    assign w_hit1 = rf.wb_load && (rf.wb_dest == rf.src1);
    assign w_hit2 = rf.wb_load && (rf.wb_dest == rf.src2);
    assign w_hitd = rf.wb_load && (rf.wb_dest == rf.issue_dest);

    assign w_haz1   = rf.use1 && r_busy[rf.src1] && !w_hit1;
    assign w_haz2   = rf.use2 && r_busy[rf.src2] && !w_hit2;
    assign w_waw    = rf.issue_load && r_busy[rf.issue_dest] && !w_hitd;
    assign w_stall  = rf.issue_valid && !rf.flush && (w_haz1 || w_haz2 || w_waw);
    assign w_accept = rf.issue_valid && !w_stall && !rf.flush;

    mux8 #(.width(width)) u_mux1 (
        .sel(rf.src1),
        .a(r_regs[0]), .b(r_regs[1]), .c(r_regs[2]), .d(r_regs[3]),
        .e(r_regs[4]), .f(r_regs[5]), .g(r_regs[6]), .h(r_regs[7]),
        .out(w_mux1)
    );

    mux8 #(.width(width)) u_mux2 (
        .sel(rf.src2),
        .a(r_regs[0]), .b(r_regs[1]), .c(r_regs[2]), .d(r_regs[3]),
        .e(r_regs[4]), .f(r_regs[5]), .g(r_regs[6]), .h(r_regs[7]),
        .out(w_mux2)
    );

    assign rf.rd_data1 = w_hit1 ? rf.wb_data : w_mux1;
    assign rf.rd_data2 = w_hit2 ? rf.wb_data : w_mux2;
    assign rf.stall    = w_stall;
    assign rf.busy     = r_busy;

    // Set is applied after clear so a new producer keeps ownership of its destination.
    always_comb begin
        w_busy_nxt = r_busy;
        if (rf.flush) begin
            w_busy_nxt = '0;
        end else begin
            if (rf.wb_load)
                w_busy_nxt[rf.wb_dest] = 1'b0;
            if (w_accept && rf.issue_load)
                w_busy_nxt[rf.issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (rf.wb_load)
                r_regs[rf.wb_dest] <= rf.wb_data;
        end
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Eight-entry, 16-bit general-purpose register file with a per-register busy scoreboard for the pipelined LC-3b datapath. It sits directly downstream of the write-back select multiplexer (regfilemux), whose output arrives here as `wb_data`. It feeds two operand read ports to decode/execute. The scoreboard tracks in-flight producers and raises `stall` to hold issue until every operand and destination hazard clears.

## Interface
- `width`, 16, data word width
- `clk`  in  1  rising-edge clock, sole clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `wb_load`  in  1  commit `wb_data` to `wb_dest` this edge
- `wb_dest`  in  3  write-back register index
- `wb_data`  in  width  write-back value (regfilemux output)
- `src1`, `src2`  in  3 each  read-port indices
- `use1`, `use2`  in  1 each  issuing instruction actually reads src1/src2
- `issue_valid`  in  1  instruction in decode requests issue
- `issue_load`  in  1  issuing instruction will write `issue_dest`
- `issue_dest`  in  3  issuing instruction destination
- `flush`  in  1  squash all in-flight producers (mispredict)
- `rd_data1`, `rd_data2`  out  width  operand values
- `stall`  out  1  issue blocked this cycle
- `busy`  out  8  scoreboard vector, bit i = register i has pending writer

## Operation
- Storage: 8 x `width` flops. Write on rising `clk` when `wb_load`, to `wb_dest`.
- Reads are combinational, with write-through bypass: if `wb_load && wb_dest == srcN`, then `rd_dataN = wb_data`. Otherwise `rd_dataN = reg[srcN]`.
- Hazard for port N: `useN && busy[srcN] && !(wb_load && wb_dest == srcN)`.
- WAW hazard: `issue_load && busy[issue_dest] && !(wb_load && wb_dest == issue_dest)`.
- `stall = issue_valid && !flush && (hazard1 || hazard2 || WAW)`. It is purely combinational.
- Issue accepted when `issue_valid && !stall && !flush`. If also `issue_load`, set `busy[issue_dest]` at the edge.
- Clear `busy[wb_dest]` at the edge when `wb_load`.
- Same register set and cleared in one cycle: set wins. The new producer owns it.
- `flush`: clears every busy bit at the edge. Issue is ignored that cycle. `wb_load` in the same cycle still commits data.
- Writes to a non-busy register (e.g. post-flush stragglers) are legal. They update data, and busy stays 0.
- No width arithmetic. Indices are 3-bit, so there is no out-of-range case.

## Timing
- Reset (async assert, sync-safe deassert by system): all 8 registers = 0 and `busy` = 8'h00. Consequences: `rd_data1/2` = 0 and `stall` = 0.
- Read latency 0 cycles (combinational from `src*` and the bypass path).
- Write latency 1 edge. Data is visible directly via bypass in the same cycle, and from storage thereafter.
- A busy bit set at edge k blocks consumers from cycle k+1. It is cleared by the `wb_load` edge, and a consumer presented in the `wb_load` cycle is released in that same cycle.
- Reset mid-operation: clears storage and scoreboard immediately, independent of `clk`.

## Structure
- Shared package `lc3b_types`: `lc3b_word` (16-bit), `lc3b_reg` (3-bit index). Use them for `wb_data`/`rd_data*` and every 3-bit index port.
- Read selection: two instances of the existing `mux8` (width = `width`), select = `srcN`, with the bypass compare in front.
- Scoreboard next-state logic stays in this module. No further sub-modules.

## Test plan
- Reset then read all: assert `rst_n` = 0 mid-cycle, read r0..r7 -> all `rd_data` = 16'h0000, `busy` = 0, `stall` = 0.
- Write/read and bypass:
  - Write r3 = 16'hBEEF with `src1` = 3 in the same cycle -> `rd_data1` = BEEF in that cycle.
  - Next cycle -> still BEEF from storage.
- RAW stall:
  - Issue writer to r5 -> `busy` = 8'h20.
  - Consumer with `use2`, `src2` = 5 -> `stall` = 1 until the `wb_load` r5 = 16'h1234 cycle. In that cycle `stall` = 0 and `rd_data2` = 1234, and `busy` = 0 after the edge.
- WAW and set-vs-clear:
  - r2 busy, issue another writer to r2 -> `stall` = 1.
  - With `wb_load` r2 and issue of writer r2 in the same cycle -> no stall, `busy[2]` = 1 after the edge.
- Unused operand: `busy[6]` = 1, `src1` = 6, `use1` = 0 -> `stall` = 0.
- Flush:
  - r1, r4 busy -> `flush` with `issue_valid` = 1 gives `stall` = 0, and `busy` = 0 after the edge with no new bit set.
  - Later `wb_load` r4 = 16'h0007 -> data written, `busy` stays 0.
